// File: rtl/ofs_asp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ofs_asp_pkg
// Purpose  : Shared constants for the ASP shim stages.
//            SHIM_AVST_DATA_WIDTH    - payload width of every shim_avst_if link
//            SHIM_AVST_RX_FIFO_DEPTH - default entry count of shim_avst_rx_fifo
// Revision : 1.0  initial release
// ============================================================================
package ofs_asp_pkg;

    localparam int SHIM_AVST_DATA_WIDTH    = 32;
    localparam int SHIM_AVST_RX_FIFO_DEPTH = 16;

    // True when v is a non-zero power of two.
    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage : ofs_asp_pkg
`default_nettype wire

// File: rtl/shim_avst_if.sv
`default_nettype none
// ============================================================================
// Module   : shim_avst_if
// Purpose  : Streaming link with ready-latency 0 (valid/ready/data).
//            source modport : drives valid/data, receives ready
//            sink   modport : receives valid/data, drives ready
// Revision : 1.0  initial release
// ============================================================================
interface shim_avst_if
    import ofs_asp_pkg::*;
#(
    parameter int DATA_WIDTH = SHIM_AVST_DATA_WIDTH
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport source (output valid, output data, input  ready);
    modport sink   (input  valid, input  data, output ready);

endinterface : shim_avst_if
`default_nettype wire

// File: rtl/shim_avst_rx_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : shim_avst_rx_fifo_mem
// Purpose  : DEPTH x DATA_WIDTH simple dual-port storage, synchronous write,
//            asynchronous read, no reset.
//            clk     - write clock
//            we      - write enable
//            wr_addr - write address
//            wr_data - write data
//            rd_addr - read address
//            rd_data - combinational read data
// Revision : 1.0  initial release
// ============================================================================
module shim_avst_rx_fifo_mem
    import ofs_asp_pkg::*;
#(
    parameter int DATA_WIDTH = SHIM_AVST_DATA_WIDTH,
    parameter int DEPTH      = SHIM_AVST_RX_FIFO_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  wire logic                  clk,
    input  wire logic                  we,
    input  wire logic [ADDR_WIDTH-1:0] wr_addr,
    input  wire logic [DATA_WIDTH-1:0] wr_data,
    input  wire logic [ADDR_WIDTH-1:0] rd_addr,
    output      logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule : shim_avst_rx_fifo_mem
`default_nettype wire

// File: rtl/shim_avst_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : shim_avst_rx_fifo
// Purpose  : Receiving end of a shim_avst_if link. Buffers upstream beats in
//            a DEPTH-entry first-word-fall-through FIFO and re-drives them
//            downstream. Upstream ready depends on registered state only.
//            clk         - single clock
//            reset       - synchronous, active-high
//            in_st       - upstream link (sink side)
//            out_st      - downstream link (source side)
//            occupancy   - registered entry count
//            almost_full - occupancy >= ALMOST_FULL_THRESH (registered)
// Revision : 1.0  initial release
// ============================================================================
module shim_avst_rx_fifo
    import ofs_asp_pkg::*;
#(
    parameter int DATA_WIDTH         = SHIM_AVST_DATA_WIDTH,
    parameter int DEPTH              = SHIM_AVST_RX_FIFO_DEPTH,
    parameter int ALMOST_FULL_THRESH = DEPTH - 2
) (
    input  wire logic             clk,
    input  wire logic             reset,
    shim_avst_if.sink             in_st,
    shim_avst_if.source           out_st,
    output      logic [$clog2(DEPTH):0] occupancy,
    output      logic             almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] c_full_count = CW'(DEPTH);
    localparam logic [CW-1:0] c_af_thresh  = CW'(ALMOST_FULL_THRESH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_almost_full;

    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_next;

    // Both handshake qualifiers come straight from the count register, so
    // downstream ready never reaches upstream ready combinationally.
    assign w_in_ready  = (r_count != c_full_count);
    assign w_out_valid = (r_count != '0);

    assign w_push = in_st.valid  && w_in_ready;
    assign w_pop  = w_out_valid  && out_st.ready;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_almost_full <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
            // Taken from the next count so it lines up with occupancy.
            r_almost_full <= (w_count_next >= c_af_thresh);
        end
    end

    // Writes are gated by reset so a handshake in the reset cycle leaves no
    // trace (memory is otherwise never cleared).
    shim_avst_rx_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) u_mem (
        .clk     (clk),
        .we      (w_push && !reset),
        .wr_addr (r_wr_ptr),
        .wr_data (in_st.data),
        .rd_addr (r_rd_ptr),
        .rd_data (out_st.data)
    );

    assign in_st.ready  = w_in_ready;
    assign out_st.valid = w_out_valid;
    assign occupancy    = r_count;
    assign almost_full  = r_almost_full;

endmodule : shim_avst_rx_fifo
`default_nettype wire

// File: tb/tb_shim_avst_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_shim_avst_rx_fifo
// Purpose  : Self-checking bench for shim_avst_rx_fifo. A queue-based FIFO
//            model predicts ready/valid/data/occupancy/almost_full each cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_shim_avst_rx_fifo;
    import ofs_asp_pkg::*;

    localparam int DW     = SHIM_AVST_DATA_WIDTH;
    localparam int DEPTH  = SHIM_AVST_RX_FIFO_DEPTH;
    localparam int THRESH = DEPTH - 2;

    logic clk = 1'b0;
    logic reset;
    logic [$clog2(DEPTH):0] occupancy;
    logic almost_full;

    shim_avst_if #(.DATA_WIDTH(DW)) in_if ();
    shim_avst_if #(.DATA_WIDTH(DW)) out_if ();

    shim_avst_rx_fifo #(
        .DATA_WIDTH         (DW),
        .DEPTH              (DEPTH),
        .ALMOST_FULL_THRESH (THRESH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_st       (in_if),
        .out_st      (out_if),
        .occupancy   (occupancy),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] got_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against the queue model.
    task automatic model_check();
        chk("in_ready",    64'(in_if.ready),  64'(model_q.size() != DEPTH));
        chk("out_valid",   64'(out_if.valid), 64'(model_q.size() != 0));
        chk("occupancy",   64'(occupancy),    64'(model_q.size()));
        chk("almost_full", 64'(almost_full),  64'(model_q.size() >= THRESH));
        if (model_q.size() != 0) begin
            chk("out_data", 64'(out_if.data), 64'(model_q[0]));
        end
    endtask

    // One clock cycle: drive at negedge, advance model at posedge, check at
    // the next negedge. pushed reports whether the beat was accepted.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r,
                       input logic rs, output logic pushed);
        logic push;
        logic pop;
        in_if.valid = v;
        in_if.data  = d;
        out_if.ready = r;
        reset       = rs;
        push = !rs && v && (model_q.size() < DEPTH);
        pop  = !rs && r && (model_q.size() > 0);
        @(posedge clk);
        if (rs) begin
            model_q.delete();
        end else begin
            if (pop) got_q.push_back(model_q.pop_front());
            if (push) model_q.push_back(d);
        end
        pushed = push;
        @(negedge clk);
        model_check();
    endtask

    initial begin
        logic p;
        int   next;
        int   budget;
        logic [DW-1:0] base;

        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b0;
        reset        = 1'b1;
        @(negedge clk);

        // Reset, then first post-reset cycle.
        cyc(1'b0, '0, 1'b0, 1'b1, p);
        cyc(1'b0, '0, 1'b0, 1'b1, p);
        cyc(1'b0, '0, 1'b1, 1'b0, p);
        chk("rst_ready", 64'(in_if.ready), 64'd1);
        chk("rst_valid", 64'(out_if.valid), 64'd0);
        chk("rst_occ",   64'(occupancy), 64'd0);

        // Single beat latency: accepted at edge N, presented at N+1.
        cyc(1'b1, DW'(32'hA5), 1'b1, 1'b0, p);
        chk("lat_valid", 64'(out_if.valid), 64'd1);
        chk("lat_data",  64'(out_if.data),  64'hA5);
        cyc(1'b0, '0, 1'b1, 1'b0, p);
        chk("lat_occ",   64'(occupancy), 64'd0);
        got_q.delete();

        // Fill with 16 beats while downstream stalls.
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, DW'(i), 1'b0, 1'b0, p);
            if (i == THRESH - 2) chk("af_below", 64'(almost_full), 64'd0);
            if (i == THRESH - 1) chk("af_at",    64'(almost_full), 64'd1);
        end
        chk("full_ready", 64'(in_if.ready), 64'd0);
        chk("full_occ",   64'(occupancy), 64'(DEPTH));
        cyc(1'b1, DW'(DEPTH), 1'b0, 1'b0, p);
        cyc(1'b1, DW'(DEPTH), 1'b0, 1'b0, p);
        chk("full_hold_occ", 64'(occupancy), 64'(DEPTH));

        // Pop one from full: slot reused only on the following cycle.
        cyc(1'b1, DW'(DEPTH), 1'b1, 1'b0, p);
        chk("pop_full_occ",   64'(occupancy), 64'(DEPTH - 1));
        chk("pop_full_ready", 64'(in_if.ready), 64'd1);
        cyc(1'b1, DW'(DEPTH), 1'b0, 1'b0, p);
        chk("refill_occ", 64'(occupancy), 64'(DEPTH));
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1, 1'b0, p);
        chk("drain_count", 64'(got_q.size()), 64'(DEPTH + 1));
        for (int i = 0; i < DEPTH + 1 && i < got_q.size(); i++) begin
            chk("order", 64'(got_q[i]), 64'(i));
        end
        got_q.delete();

        // 64 beats with random upstream gaps and downstream stalls.
        base   = DW'(32'h1000);
        next   = 0;
        budget = 2000;
        while ((got_q.size() < 64) && (budget > 0)) begin
            logic v;
            v = (next < 64) && (($urandom % 4) != 0);
            cyc(v, base + DW'(next), ($urandom % 3) != 0, 1'b0, p);
            if (p) next++;
            budget--;
        end
        chk("stream_timeout", 64'(budget > 0), 64'd1);
        chk("stream_count", 64'(got_q.size()), 64'd64);
        for (int i = 0; i < 64 && i < got_q.size(); i++) begin
            chk("stream_seq", 64'(got_q[i]), 64'(base + DW'(i)));
        end
        got_q.delete();

        // Reset with 8 beats buffered discards them.
        for (int i = 0; i < 8; i++) cyc(1'b1, DW'(32'h700 + i), 1'b0, 1'b0, p);
        chk("pre_rst_occ", 64'(occupancy), 64'd8);
        cyc(1'b1, DW'(32'hDEAD), 1'b1, 1'b1, p);
        chk("midrst_occ",   64'(occupancy), 64'd0);
        chk("midrst_valid", 64'(out_if.valid), 64'd0);
        cyc(1'b1, DW'(32'hBEEF), 1'b0, 1'b0, p);
        chk("post_rst_data", 64'(out_if.data), 64'hBEEF);
        cyc(1'b0, '0, 1'b1, 1'b0, p);
        chk("post_rst_occ", 64'(occupancy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_shim_avst_rx_fifo
`default_nettype wire

// File: doc/shim_avst_rx_fifo.md
Name: shim_avst_rx_fifo

Overview:
- Receiving end of a shim_avst_if link: terminates an upstream source on the sink modport and re-drives the data downstream on a source modport.
- Decouples the two sides with a DEPTH-entry first-word-fall-through buffer.
- Upstream ready is a function of registered state only, so no combinational ready path runs from downstream to upstream.
- Sits between ASP shim stages wherever a link crosses a timing-critical boundary or needs elastic storage.

Parameters:
- DATA_WIDTH, ofs_asp_pkg::SHIM_AVST_DATA_WIDTH, payload width of both interfaces.
- DEPTH, ofs_asp_pkg::SHIM_AVST_RX_FIFO_DEPTH (16), entry count; power of 2, >= 2.
- ALMOST_FULL_THRESH, DEPTH-2, occupancy at or above which almost_full asserts; range 1..DEPTH.

Ports:
- clk  input  1  single clock for all logic.
- reset  input  1  synchronous, active-high reset.
- in_st  shim_avst_if.sink  DATA_WIDTH bundle  upstream link: valid/data in, ready out.
- out_st  shim_avst_if.source  DATA_WIDTH bundle  downstream link: ready in, valid/data out.
- occupancy  output  $clog2(DEPTH)+1  current entry count.
- almost_full  output  1  occupancy >= ALMOST_FULL_THRESH.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is synchronous and active-high; it is sampled on the rising edge of clk.
- Transfer rules (ready-latency 0 on both sides):
  - A beat transfers when valid && ready in the same cycle.
  - in_st.valid is honoured whether or not ready is high. Upstream must hold data stable while valid && !ready.
- State:
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH.
  - count, $clog2(DEPTH)+1 bits, range 0..DEPTH.
- in_st.ready = (count != DEPTH). Decoded from the count register only.
- out_st.valid = (count != 0).
- out_st.data = mem[rd_ptr], read combinationally (FWFT).
- Push = in_st.valid && in_st.ready: write mem[wr_ptr], then wr_ptr++.
- Pop = out_st.valid && out_st.ready: rd_ptr++.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: a beat accepted into an empty FIFO at edge N is presented on out_st at cycle N+1. There is no bypass path.
- Throughput: one beat per cycle sustained when downstream is always ready.
- Full: ready is low and no write occurs. A simultaneous pop frees a slot, and ready rises the next cycle (no same-cycle reuse of the slot).
- Empty: out_st.valid is low and out_st.data is don't-care. A push into the empty FIFO cannot be popped in the same cycle.
- Simultaneous push and pop at any 0 < count < DEPTH: count is held and both pointers advance.
- Pointer wrap: DEPTH-1 -> 0 with no bubble.
- Downstream stall: out_st.valid and out_st.data stay stable until out_st.ready is sampled high.
- Reset values:
  - wr_ptr = rd_ptr = count = 0.
  - in_st.ready = 1 from the first post-reset cycle.
  - out_st.valid = 0, occupancy = 0, almost_full = 0.
  - Memory contents are not reset.
- Reset mid-operation: all buffered beats are discarded. A handshake occurring in the reset cycle is ignored.
- occupancy = count, registered.
- almost_full is registered and computed from next-count, so it is cycle-aligned with occupancy.

Decomposition:
- Shared package ofs_asp_pkg:
  - Add the constant SHIM_AVST_RX_FIFO_DEPTH = 16.
  - Reuse the existing SHIM_AVST_DATA_WIDTH.
- Sub-module shim_avst_rx_fifo_mem: simple dual-port storage with synchronous write and asynchronous read, DEPTH x DATA_WIDTH, no reset. Pointer, count and handshake logic stay in the top module.

Test Plan:
- Reset release with in_st.valid=0 -> ready=1, out_st.valid=0, occupancy=0 on the first cycle after reset deasserts.
- Push 0xA5 at edge N, out_st.ready=1 -> out_st.valid=1 with data=0xA5 at cycle N+1, popped at edge N+1, occupancy back to 0.
- out_st.ready=0, push 16 beats 0..15 -> ready drops after the 16th; occupancy=16; almost_full=1 from occupancy 14; the 17th beat held by upstream is not written.
- From full, hold in_st.valid with data 16, pulse out_st.ready for one cycle -> beat 0 popped, occupancy 15, ready=1 the next cycle, beat 16 accepted, ordering 1..16 preserved.
- Continuous push and pop of 64 incrementing beats with random out_st.ready stalls -> output sequence identical to input, pointers wrap four times, no loss or duplication, data stable during stalls.
- Assert reset with 8 beats buffered -> occupancy=0, out_st.valid=0 next cycle; a beat pushed after reset is the first beat seen at the output.
